// File: rtl/xbar_slave_sched.sv
// Per-slave scheduler: round-robin over the write and read requesters of every master,
// issuing one command at a time to the slave and routing the read response back.
module xbar_slave_sched #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MASTER_NUM = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [MASTER_NUM-1:0]             rd_req,
  input  logic [MASTER_NUM*AWIDTH-1:0]      rd_addr,
  output logic [MASTER_NUM-1:0]             rd_pop,
  input  logic [MASTER_NUM-1:0]             wr_req,
  input  logic [MASTER_NUM*AWIDTH-1:0]      wr_addr,
  input  logic [MASTER_NUM*DWIDTH-1:0]      wr_data,
  output logic [MASTER_NUM-1:0]             wr_ack,
  output logic                              sl_req,
  output logic                              sl_we,
  output logic [AWIDTH-1:0]                 sl_addr,
  output logic [DWIDTH-1:0]                 sl_wdata,
  input  logic                              sl_ack,
  input  logic                              sl_resp,
  input  logic [DWIDTH-1:0]                 sl_rdata,
  output logic [MASTER_NUM-1:0]             resp_valid,
  output logic [DWIDTH-1:0]                 resp_data,
  output logic                              resp_err,
  output logic                              busy,
  output logic [$clog2(2*MASTER_NUM)-1:0]   grant_id
);

  localparam int RING = 2 * MASTER_NUM;
  localparam int IW   = $clog2(RING);
  localparam int MW   = IW - 1;
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       g_q;
  logic                we_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [CW-1:0]       cnt;

  logic [RING-1:0]     req_vec;
  logic                found;
  logic [IW-1:0]       pick;
  logic [IW:0]         sum;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_wdata;
  logic [MASTER_NUM-1:0] m_onehot;
  logic                ack_fire;
  logic                timeout_hit;

  // Ring layout: even index = write of master m, odd index = read of master m.
  always_comb begin
    req_vec = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      req_vec[2*m]   = wr_req[m];
      req_vec[2*m+1] = rd_req[m];
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < RING; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(RING)) sum = sum - (IW+1)'(RING);
      if (!found && req_vec[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (pick[IW-1:1] == MW'(m)) begin
        sel_addr  = pick[0] ? rd_addr[m*AWIDTH +: AWIDTH] : wr_addr[m*AWIDTH +: AWIDTH];
        sel_wdata = pick[0] ? '0 : wr_data[m*DWIDTH +: DWIDTH];
      end
    end
  end

  assign m_onehot    = MASTER_NUM'(1) << g_q[IW-1:1];
  assign ack_fire    = (state == ISSUE) && sl_ack;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    sl_req   = 1'b0;
    sl_we    = 1'b0;
    wr_ack   = '0;
    rd_pop   = '0;
    unique case (state)
      IDLE: begin
        if (found) state_nx = ISSUE;
      end
      ISSUE: begin
        sl_req = 1'b1;
        sl_we  = we_q;
        if (sl_ack) begin
          if (we_q) begin
            wr_ack   = m_onehot;
            state_nx = IDLE;
          end else begin
            rd_pop   = m_onehot;
            state_nx = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (sl_resp || timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign sl_addr  = addr_q;
  assign sl_wdata = wdata_q;
  assign grant_id = g_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr        <= '0;
      g_q        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            g_q     <= pick;
            ptr     <= (pick == IW'(RING - 1)) ? '0 : pick + IW'(1);
            we_q    <= ~pick[0];
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
          end
        end
        ISSUE: begin
          if (ack_fire && !we_q) cnt <= '0;
        end
        WAIT_RESP: begin
          cnt <= cnt + CW'(1);
          // A response arriving on the timeout cycle still counts as a good response.
          if (sl_resp) begin
            resp_valid <= m_onehot;
            resp_data  <= sl_rdata;
          end else if (timeout_hit) begin
            resp_valid <= m_onehot;
            resp_data  <= '0;
            resp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_slave_sched.sv
// Directed bench for xbar_slave_sched: a per-cycle vector table for grant order and
// basic transactions, plus hand-written timeout, resp/timeout collision and reset cases.
module tb_xbar_slave_sched;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MN = 2;
  localparam int TO = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic [MN-1:0]     rd_req, wr_req;
  logic [MN*AW-1:0]  rd_addr, wr_addr;
  logic [MN*DW-1:0]  wr_data;
  logic [MN-1:0]     rd_pop, wr_ack, resp_valid;
  logic              sl_req, sl_we, sl_ack, sl_resp, resp_err, busy;
  logic [AW-1:0]     sl_addr;
  logic [DW-1:0]     sl_wdata, sl_rdata, resp_data;
  logic [1:0]        grant_id;

  int compared   = 0;
  int mismatched = 0;

  xbar_slave_sched #(.AWIDTH(AW), .DWIDTH(DW), .MASTER_NUM(MN), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_pop(rd_pop),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .sl_req(sl_req), .sl_we(sl_we), .sl_addr(sl_addr), .sl_wdata(sl_wdata),
    .sl_ack(sl_ack), .sl_resp(sl_resp), .sl_rdata(sl_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_wr_ack;
    logic [1:0]  e_rd_pop;
    logic [1:0]  e_rv;
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_busy;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = '0; wr_req = '0; sl_ack = 1'b0; sl_resp = 1'b0; sl_rdata = '0;
  endtask

  // Read issued from IDLE, acked, then WAIT_RESP held; resp_at < 0 means never respond.
  task automatic read_wait(input string tag, input int m, input logic [1:0] exp_gid,
                           input int resp_at, input logic [31:0] rdata);
    rd_req = 2'b01 << m; sl_ack = 1'b1;
    next_cycle();
    @(negedge aclk);
    check({tag, " rd_pop"}, 64'(rd_pop), 64'(2'b01 << m));
    check({tag, " gid"}, 64'(grant_id), 64'(exp_gid));
    next_cycle();
    rd_req = '0; sl_ack = 1'b0;
    for (int w = 0; w < TO; w++) begin
      if (w == resp_at) begin
        sl_resp = 1'b1; sl_rdata = rdata;
      end
      @(negedge aclk);
      check($sformatf("%s w%0d busy", tag, w), 64'(busy), 64'(1));
      check($sformatf("%s w%0d rv", tag, w), 64'(resp_valid), 64'(0));
      next_cycle();
      sl_resp = 1'b0; sl_rdata = '0;
      if (w == resp_at) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    areset  = 1'b1;
    wr_addr = {32'h30, 32'h10};
    wr_data = {32'h5A, 32'hA5};
    rd_addr = {32'h20, 32'h40};
    idle_inputs();

    // rd, wr, ack, resp, rdata | req, we, addr, wdata, wr_ack, rd_pop, rv, err, rdata, busy, gid
    vecs.push_back('{2'b00,2'b01,1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd0}); // 0
    vecs.push_back('{2'b00,2'b01,1'b1,1'b0,32'h0,    1'b1,1'b1,32'h10,32'hA5,2'b01,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd0}); // 1 m0 write
    vecs.push_back('{2'b00,2'b00,1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd0}); // 2
    vecs.push_back('{2'b10,2'b00,1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd0}); // 3
    vecs.push_back('{2'b10,2'b00,1'b1,1'b0,32'h0,    1'b1,1'b0,32'h20,32'h0, 2'b00,2'b10,2'b00,1'b0,32'h0,   1'b1,2'd3}); // 4 m1 read
    vecs.push_back('{2'b00,2'b00,1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd3}); // 5
    vecs.push_back('{2'b00,2'b00,1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd3}); // 6
    vecs.push_back('{2'b00,2'b00,1'b0,1'b1,32'hDEAD, 1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd3}); // 7
    vecs.push_back('{2'b00,2'b00,1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b10,1'b0,32'hDEAD,1'b0,2'd3}); // 8
    vecs.push_back('{2'b00,2'b00,1'b0,1'b1,32'hBEEF, 1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd3}); // 9 stray
    vecs.push_back('{2'b00,2'b00,1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd3}); // 10
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd3}); // 11
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b1,1'b1,32'h10,32'hA5,2'b01,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd0}); // 12 idx0
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd0}); // 13
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b1,1'b0,32'h40,32'h0, 2'b00,2'b01,2'b00,1'b0,32'h0,   1'b1,2'd1}); // 14 idx1
    vecs.push_back('{2'b11,2'b11,1'b1,1'b1,32'h1111, 1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd1}); // 15
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b01,1'b0,32'h1111,1'b0,2'd1}); // 16
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b1,1'b1,32'h30,32'h5A,2'b10,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd2}); // 17 idx2
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd2}); // 18
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b1,1'b0,32'h20,32'h0, 2'b00,2'b10,2'b00,1'b0,32'h0,   1'b1,2'd3}); // 19 idx3
    vecs.push_back('{2'b11,2'b11,1'b1,1'b1,32'h2222, 1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd3}); // 20
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b10,1'b0,32'h2222,1'b0,2'd3}); // 21
    vecs.push_back('{2'b11,2'b11,1'b1,1'b0,32'h0,    1'b1,1'b1,32'h10,32'hA5,2'b01,2'b00,2'b00,1'b0,32'h0,   1'b1,2'd0}); // 22 idx0 again
    vecs.push_back('{2'b00,2'b00,1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0, 32'h0, 2'b00,2'b00,2'b00,1'b0,32'h0,   1'b0,2'd0}); // 23

    // Reset state
    next_cycle();
    next_cycle();
    check("rst sl_req", 64'(sl_req), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst outs", 64'({wr_ack, rd_pop, resp_valid, resp_err, sl_we, grant_id}), 64'(0));
    check("rst resp_data", 64'(resp_data), 64'(0));
    check("rst sl_addr", 64'(sl_addr), 64'(0));
    areset = 1'b0;

    foreach (vecs[i]) begin
      rd_req = vecs[i].rd; wr_req = vecs[i].wr; sl_ack = vecs[i].ack;
      sl_resp = vecs[i].resp; sl_rdata = vecs[i].rdata;
      @(negedge aclk);
      check($sformatf("v%0d sl_req", i), 64'(sl_req), 64'(vecs[i].e_req));
      check($sformatf("v%0d wr_ack", i), 64'(wr_ack), 64'(vecs[i].e_wr_ack));
      check($sformatf("v%0d rd_pop", i), 64'(rd_pop), 64'(vecs[i].e_rd_pop));
      check($sformatf("v%0d resp_valid", i), 64'(resp_valid), 64'(vecs[i].e_rv));
      check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("v%0d grant_id", i), 64'(grant_id), 64'(vecs[i].e_gid));
      if (vecs[i].e_req) begin
        check($sformatf("v%0d sl_we", i), 64'(sl_we), 64'(vecs[i].e_we));
        check($sformatf("v%0d sl_addr", i), 64'(sl_addr), 64'(vecs[i].e_addr));
        if (vecs[i].e_we)
          check($sformatf("v%0d sl_wdata", i), 64'(sl_wdata), 64'(vecs[i].e_wdata));
      end
      if (vecs[i].e_rv != 2'b00) begin
        check($sformatf("v%0d resp_data", i), 64'(resp_data), 64'(vecs[i].e_rdata));
        check($sformatf("v%0d resp_err", i), 64'(resp_err), 64'(vecs[i].e_err));
      end
      next_cycle();
    end
    idle_inputs();

    // Timeout: m0 read (ptr=1 so idx1), never answered; response at ack+TIMEOUT+1
    read_wait("to", 0, 2'd1, -1, 32'h0);
    @(negedge aclk);
    check("to resp_valid", 64'(resp_valid), 64'(2'b01));
    check("to resp_err", 64'(resp_err), 64'(1));
    check("to resp_data", 64'(resp_data), 64'(0));
    check("to busy", 64'(busy), 64'(0));
    next_cycle();
    @(negedge aclk);
    check("to rv pulse", 64'(resp_valid), 64'(0));
    next_cycle();

    // sl_resp on the very cycle the counter reaches TIMEOUT-1: response wins
    read_wait("col", 1, 2'd3, TO - 1, 32'h7777);
    @(negedge aclk);
    check("col resp_valid", 64'(resp_valid), 64'(2'b10));
    check("col resp_err", 64'(resp_err), 64'(0));
    check("col resp_data", 64'(resp_data), 64'(32'h7777));
    next_cycle();

    // Reset during WAIT_RESP: m0 read (ptr=0 so idx1, ptr becomes 2), then abort
    rd_req = 2'b01; sl_ack = 1'b1;
    next_cycle();
    @(negedge aclk);
    check("rs rd_pop", 64'(rd_pop), 64'(2'b01));
    next_cycle();
    rd_req = '0; sl_ack = 1'b0;
    @(negedge aclk);
    check("rs wait busy", 64'(busy), 64'(1));
    areset = 1'b1;
    #1;
    check("rs async busy", 64'(busy), 64'(0));
    check("rs async sl_req", 64'(sl_req), 64'(0));
    check("rs async gid", 64'(grant_id), 64'(0));
    sl_resp = 1'b1; sl_rdata = 32'h9999;
    next_cycle();
    check("rs rv", 64'({resp_valid, rd_pop, wr_ack}), 64'(0));
    #2;
    areset = 1'b0;
    sl_resp = 1'b0; sl_rdata = '0;
    rd_req = 2'b11; wr_req = 2'b11; sl_ack = 1'b1;
    next_cycle();
    @(negedge aclk);
    check("rs regrant sl_req", 64'(sl_req), 64'(1));
    check("rs regrant gid", 64'(grant_id), 64'(0));
    check("rs regrant wr_ack", 64'(wr_ack), 64'(2'b01));
    check("rs no rv", 64'(resp_valid), 64'(0));
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
